// File: rtl/noise_envelope_gen.sv
// Noise envelope generator: paces an upstream LFSR, samples its MSB and scales it by a decaying volume.
// Latency: trigger loads on its edge; first step strobe period+1 cycles later; strobe to noise_bit is 2 cycles.
// No backpressure: the trigger is a 1-cycle pulse and always wins over a coincident decay step or divider reload.
module noise_envelope_gen #(
  parameter int NBITS       = 8,
  parameter int PERIOD_BITS = 8,
  parameter int VOL_BITS    = 4,
  parameter int DECAY_BITS  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_trigger,
  input  logic [PERIOD_BITS-1:0] i_period,
  input  logic [DECAY_BITS-1:0]  i_decay_rate,
  input  logic [VOL_BITS-1:0]    i_start_vol,
  input  logic [NBITS-1:0]       i_lfsr,
  output logic                   o_lfsr_enable,
  output logic                   o_noise_bit,
  output logic [VOL_BITS-1:0]    o_amplitude,
  output logic                   o_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECAY   = 2'd1,
    SUSTAIN = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [PERIOD_BITS-1:0] r_per;
  logic [PERIOD_BITS-1:0] r_div_cnt;
  logic [DECAY_BITS-1:0]  r_dec;
  logic [DECAY_BITS-1:0]  r_env_cnt;
  logic [VOL_BITS-1:0]    r_vol;
  logic                   r_lfsr_enable;
  logic                   r_step_d;
  logic                   r_noise_bit;

  logic w_load;
  logic w_stop;
  logic w_decay_end;
  logic w_to_idle;
  logic w_unused_lfsr;

  // Only the MSB of the LFSR word is consumed; the rest is tied off here.
  assign w_unused_lfsr = &{1'b0, i_lfsr[NBITS-2:0]};

  // A trigger with non-zero volume (re)starts a note; with zero volume it stops a running note.
  assign w_load      = i_trigger && (i_start_vol != '0);
  assign w_stop      = i_trigger && (i_start_vol == '0) && (r_state != IDLE);
  // The last volume step ends the note; a trigger on the same edge takes priority.
  assign w_decay_end = (r_state == DECAY) && !i_trigger && (r_env_cnt == '0) && (r_vol <= 1);
  assign w_to_idle   = w_stop || w_decay_end;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state logic: load beats stop/decay end; zero decay rate means the note sustains.
  always_comb begin
    w_next_state = r_state;
    if (w_load) begin
      w_next_state = (i_decay_rate == '0) ? SUSTAIN : DECAY;
    end else if (w_to_idle) begin
      w_next_state = IDLE;
    end
  end

  // Envelope: latch note parameters on trigger, then step volume down every dec_r+1 cycles in DECAY.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_per     <= '0;
      r_dec     <= '0;
      r_env_cnt <= '0;
      r_vol     <= '0;
    end else if (w_load) begin
      r_per     <= i_period;
      r_dec     <= i_decay_rate;
      r_env_cnt <= i_decay_rate;
      r_vol     <= i_start_vol;
    end else if (w_to_idle) begin
      r_env_cnt <= '0;
      r_vol     <= '0;
    end else if (r_state == DECAY) begin
      if (r_env_cnt == '0) begin
        r_env_cnt <= r_dec;
        r_vol     <= r_vol - 1'b1;
      end else begin
        r_env_cnt <= r_env_cnt - 1'b1;
      end
    end
  end

  // Step divider: one-cycle LFSR enable every per_r+1 cycles while a note plays, never on the IDLE entry edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt     <= '0;
      r_lfsr_enable <= 1'b0;
    end else if (w_load) begin
      r_div_cnt     <= i_period;
      r_lfsr_enable <= 1'b0;
    end else if (w_to_idle || (r_state == IDLE)) begin
      r_div_cnt     <= '0;
      r_lfsr_enable <= 1'b0;
    end else if (r_div_cnt == '0) begin
      r_div_cnt     <= r_per;
      r_lfsr_enable <= 1'b1;
    end else begin
      r_div_cnt     <= r_div_cnt - 1'b1;
      r_lfsr_enable <= 1'b0;
    end
  end

  // Sample the LFSR MSB one cycle after the strobe, once the LFSR has advanced; cleared when the note ends.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step_d    <= 1'b0;
      r_noise_bit <= 1'b0;
    end else begin
      r_step_d <= r_lfsr_enable;
      if (w_to_idle) begin
        r_noise_bit <= 1'b0;
      end else if ((r_state != IDLE) && r_step_d) begin
        r_noise_bit <= i_lfsr[NBITS-1];
      end
    end
  end

  assign o_lfsr_enable = r_lfsr_enable;
  assign o_noise_bit   = r_noise_bit;
  assign o_busy        = (r_state != IDLE);
  assign o_amplitude   = ((r_state != IDLE) && r_noise_bit) ? r_vol : '0;

endmodule

// File: tb/tb_noise_envelope_gen.sv
// Directed bench for noise_envelope_gen: reset, divider pacing, sampling, decay, retrigger and stop.
// Expected values are hand-derived cycle counts relative to the trigger edge E0.
// Inputs change 1ns after a rising edge; outputs are checked at that same point.
module tb_noise_envelope_gen;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_trigger;
  logic [7:0] i_period;
  logic [7:0] i_decay_rate;
  logic [3:0] i_start_vol;
  logic [7:0] i_lfsr;
  logic       o_lfsr_enable;
  logic       o_noise_bit;
  logic [3:0] o_amplitude;
  logic       o_busy;

  int n_vec = 0;
  int n_err = 0;

  noise_envelope_gen #(
    .NBITS(8), .PERIOD_BITS(8), .VOL_BITS(4), .DECAY_BITS(8)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_trigger(i_trigger), .i_period(i_period),
    .i_decay_rate(i_decay_rate), .i_start_vol(i_start_vol), .i_lfsr(i_lfsr),
    .o_lfsr_enable(o_lfsr_enable), .o_noise_bit(o_noise_bit),
    .o_amplitude(o_amplitude), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply a one-cycle trigger; returns just after edge E0.
  task automatic trig(input logic [7:0] per, input logic [7:0] dec, input logic [3:0] vol);
    i_trigger    = 1'b1;
    i_period     = per;
    i_decay_rate = dec;
    i_start_vol  = vol;
    step();
    i_trigger    = 1'b0;
  endtask

  initial begin
    logic [3:0] pat;
    logic       nb;
    i_rst_n = 1'b0; i_trigger = 1'b0; i_period = '0; i_decay_rate = '0;
    i_start_vol = '0; i_lfsr = '0;
    #2;
    chk("rst_busy", o_busy, 0);
    chk("rst_en", o_lfsr_enable, 0);
    chk("rst_noise", o_noise_bit, 0);
    chk("rst_amp", o_amplitude, 0);
    step(); step();
    i_rst_n = 1'b1;
    step();

    // 1. Reset asserted mid-DECAY while amplitude is non-zero.
    i_lfsr = 8'h80;
    trig(8'd0, 8'd5, 4'd7);
    step(); step(); step();
    chk("t1_busy_pre", o_busy, 1);
    chk("t1_amp_pre", o_amplitude, 7);
    #3 i_rst_n = 1'b0;
    #1;
    chk("t1_busy_async", o_busy, 0);
    chk("t1_en_async", o_lfsr_enable, 0);
    chk("t1_noise_async", o_noise_bit, 0);
    chk("t1_amp_async", o_amplitude, 0);
    step();
    i_rst_n = 1'b1;
    step(); step();
    chk("t1_idle_after", o_busy, 0);
    chk("t1_en_after", o_lfsr_enable, 0);

    // 2. period=3, sustain, vol=15: strobe every 4 cycles, noise sampled at E6, E10, E14.
    pat = 4'b1010;
    i_lfsr = 8'h00;
    trig(8'd3, 8'd0, 4'd15);
    chk("t2_busy", o_busy, 1);
    chk("t2_en0", o_lfsr_enable, 0);
    nb = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      // MSB at non-sampling edges is the inverse of the sampled value, so a wrong sample point shows.
      i_lfsr = {((c % 4) == 2) ? pat[c / 4] : ~pat[c / 4], 7'h2a};
      step();
      if (c >= 6 && (c % 4) == 2) nb = pat[c / 4];
      chk($sformatf("t2_en_c%0d", c), o_lfsr_enable, (c % 4) == 0 ? 1 : 0);
      chk($sformatf("t2_noise_c%0d", c), o_noise_bit, nb);
      chk($sformatf("t2_amp_c%0d", c), o_amplitude, nb ? 15 : 0);
    end

    // 5. Stop while in SUSTAIN with noise_bit high and a sample pending.
    i_lfsr = 8'hff;
    trig(8'd3, 8'd0, 4'd0);
    chk("t5_busy", o_busy, 0);
    chk("t5_noise", o_noise_bit, 0);
    chk("t5_en", o_lfsr_enable, 0);
    step();
    chk("t5_noise_hold", o_noise_bit, 0);
    chk("t5_amp_hold", o_amplitude, 0);

    // 3. period=0, decay=2, vol=2: vol 2->1 at E3, 1->0 and IDLE at E6.
    i_lfsr = 8'h80;
    trig(8'd0, 8'd2, 4'd2);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) step();
      chk($sformatf("t3_vol_c%0d", c), dut.r_vol, (c < 3) ? 2 : (c < 6) ? 1 : 0);
      chk($sformatf("t3_busy_c%0d", c), o_busy, (c < 6) ? 1 : 0);
      chk($sformatf("t3_en_c%0d", c), o_lfsr_enable, (c >= 1 && c <= 5) ? 1 : 0);
      chk($sformatf("t3_amp_c%0d", c), o_amplitude, (c >= 3 && c <= 5) ? 1 : 0);
    end

    // 4. Retrigger with vol=9 on the edge where a decay step would fire.
    trig(8'd0, 8'd3, 4'd5);
    step(); step(); step();
    chk("t4_env_zero", dut.r_env_cnt, 0);
    chk("t4_vol_pre", dut.r_vol, 5);
    trig(8'd0, 8'd6, 4'd9);
    chk("t4_vol_load", dut.r_vol, 9);
    chk("t4_env_load", dut.r_env_cnt, 6);
    chk("t4_busy", o_busy, 1);
    for (int c = 1; c <= 6; c++) step();
    chk("t4_vol_hold", dut.r_vol, 9);
    step();
    chk("t4_vol_step", dut.r_vol, 8);
    chk("t4_amp_step", o_amplitude, 8);
    trig(8'd0, 8'd0, 4'd0);
    chk("t4_stop_busy", o_busy, 0);

    // 6. Zero-volume trigger while IDLE does nothing.
    trig(8'd0, 8'd1, 4'd0);
    chk("t6_busy0", o_busy, 0);
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("t6_en_c%0d", c), o_lfsr_enable, 0);
      chk($sformatf("t6_busy_c%0d", c), o_busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
